// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory req/ack bus and IF/ID slot.
// master = fetch stage, slave = memory/decode side.
interface fetch_stage_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [ILEN-1:0] imem_rdata;
  logic            ifid_valid;
  logic [XLEN-1:0] ifid_pc;
  logic [ILEN-1:0] ifid_instr;
  logic            ifid_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output ifid_valid, ifid_pc, ifid_instr,
    input  ifid_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  ifid_valid, ifid_pc, ifid_instr,
    output ifid_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage wrapped around the PC register.
// Fetches over imem req/ack, feeds IF/ID, absorbs redirects.
module fetch_stage #(
  parameter int              XLEN      = 64,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_stage_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DROP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [XLEN-1:0] r_req_addr;
  logic            r_ifid_valid;
  logic [XLEN-1:0] r_ifid_pc;
  logic [ILEN-1:0] r_ifid_instr;
  logic            r_skid_valid;
  logic [XLEN-1:0] r_skid_pc;
  logic [ILEN-1:0] r_skid_instr;

  logic            w_req;
  logic            w_ack;
  logic            w_free;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_inc;

  assign w_tgt  = redirect_pc & ~XLEN'(3);
  assign w_inc  = pc_cur + XLEN'(4);
  assign w_req  = (r_state == S_REQ) || (r_state == S_DROP);
  assign w_ack  = w_req && bus.imem_ack;
  assign w_free = !r_ifid_valid || bus.ifid_ready;

  assign bus.imem_addr  = r_req_addr;
  assign bus.ifid_valid = r_ifid_valid;
  assign bus.ifid_pc    = r_ifid_pc;
  assign bus.ifid_instr = r_ifid_valid ? r_ifid_instr : NOP_INSTR;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // next state; redirect wins everywhere, an unacked fetch goes DROP
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (redirect_valid)
          w_state_nxt = w_ack ? S_REQ : S_DROP;
        else if (w_ack && !w_free)
          w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (redirect_valid || bus.ifid_ready)
          w_state_nxt = S_REQ;
      end
      S_DROP: begin
        if (w_ack) w_state_nxt = S_REQ;
      end
    endcase
  end

  // memory request and PC register next value
  always_comb begin
    bus.imem_req = w_req;
    pc_next      = pc_cur;
    if (rst) begin
      if (redirect_valid)
        pc_next = w_tgt;
      else if (w_ack && r_state == S_REQ)
        pc_next = w_inc;
    end
  end

  // request address, IF/ID slot and skid entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_addr   <= '0;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_INSTR;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      r_ifid_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      if (!w_req || w_ack)
        r_req_addr <= w_tgt;
    end else begin
      unique case (r_state)
        S_IDLE: r_req_addr <= pc_cur;
        S_REQ: begin
          if (w_ack) begin
            r_req_addr <= w_inc;
            if (w_free) begin
              r_ifid_valid <= 1'b1;
              r_ifid_pc    <= r_req_addr;
              r_ifid_instr <= bus.imem_rdata;
            end else begin
              r_skid_valid <= 1'b1;
              r_skid_pc    <= r_req_addr;
              r_skid_instr <= bus.imem_rdata;
            end
          end else if (bus.ifid_ready) begin
            r_ifid_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (bus.ifid_ready) begin
            r_ifid_valid <= r_skid_valid;
            r_ifid_pc    <= r_skid_pc;
            r_ifid_instr <= r_skid_instr;
            r_skid_valid <= 1'b0;
          end
        end
        S_DROP: begin
          if (w_ack) r_req_addr <= pc_cur;
        end
      endcase
    end
  end

endmodule
